// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//
// Purpose:
//   Sends one command byte from the host to a PS/2 keyboard. The host holds
//   PS2_CLK low to inhibit the device, presents the start bit, releases the
//   clock and then shifts out 8 data bits (LSB first), odd parity and a
//   released stop bit. Each bit changes on the falling edges that the device
//   generates. The device's acknowledge bit is sampled on the 11th falling
//   edge. When both lines return high, the module reports completion.
//
// Handshake (tx_valid / tx_ready):
//   tx_ready is high only in IDLE. A byte is accepted on the rising clk edge
//   where tx_valid && tx_ready. tx_valid at any other time, including the
//   DONE/ERR cycle, is ignored and is not queued. tx_done and tx_err are
//   mutually exclusive one-cycle pulses that close every accepted transfer.
//   A reset ends a transfer silently, with no pulse.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active low
//   tx_data[7:0] in   command byte
//   tx_valid     in   send request
//   tx_ready     out  high in IDLE
//   ps2_clk_in   in   PS2_CLK line level (asynchronous)
//   ps2_data_in  in   PS2_DATA line level (asynchronous)
//   ps2_clk_oe   out  1 = pull PS2_CLK low
//   ps2_data_oe  out  1 = pull PS2_DATA low
//   tx_done      out  one-cycle pulse: byte sent and acknowledged
//   tx_err       out  one-cycle pulse: no acknowledge or timeout
//   busy         out  high in every state except IDLE
// ----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 21) ? $clog2(TIMEOUT_CYCLES + 1) : 21;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    DONE      = 3'd6,
    ERR       = 3'd7
  } state_t;

  state_t state;
  state_t state_nxt;

  // synchronizers; the idle line level is 1
  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  logic [IW-1:0] inh_cnt;   // cycles spent in INHIBIT
  logic [3:0]    fall_cnt;  // falling edges seen in SHIFT
  logic [TW-1:0] to_cnt;    // cycles since leaving IDLE, saturating
  logic [7:0]    tx_byte;
  logic          parity;
  logic          data_q;    // registered data drive used during SHIFT
  logic          timeout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall    = clk_prev & ~clk_s2;
  assign timeout = (to_cnt >= TO_LAST);

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and outputs
  always_comb begin
    state_nxt   = state;
    tx_ready    = 1'b0;
    busy        = 1'b1;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;

    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) state_nxt = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        // the start bit overlaps the final inhibit cycle
        ps2_data_oe = (inh_cnt == INH_LAST);
        if (inh_cnt == INH_LAST) state_nxt = REQ;
      end
      REQ: begin
        ps2_data_oe = 1'b1;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        ps2_data_oe = data_q;
        // fall_cnt == 9 means this is the 10th fall (stop bit)
        if (fall && (fall_cnt == 4'd9)) state_nxt = ACK;
      end
      ACK: begin
        if (fall) state_nxt = data_s2 ? ERR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (clk_s2 && data_s2) state_nxt = DONE;
      end
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        tx_err    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (timeout && (state inside {INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE})) begin
      state_nxt = ERR;
    end
  end

  // datapath: counters and the shift bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      inh_cnt  <= '0;
      fall_cnt <= '0;
      to_cnt   <= '0;
      tx_byte  <= '0;
      parity   <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        to_cnt <= '0;
        if (tx_valid) begin
          tx_byte <= tx_data;
          parity  <= ~^tx_data;
          inh_cnt <= '0;
        end
      end else if (to_cnt != '1) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if ((state == INHIBIT) && (inh_cnt != INH_LAST)) begin
        inh_cnt <= inh_cnt + 1'b1;
      end

      if (state == REQ) begin
        fall_cnt <= '0;
        data_q   <= 1'b1;  // keep the start bit until the first fall
      end

      if ((state == SHIFT) && fall) begin
        fall_cnt <= fall_cnt + 4'd1;
        if (fall_cnt < 4'd8) begin
          data_q <= ~tx_byte[fall_cnt[2:0]];
        end else if (fall_cnt == 4'd8) begin
          data_q <= ~parity;
        end else begin
          data_q <= 1'b0;  // stop bit: release the line
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Directed bench for ps2_host_tx with a small keyboard model on open-drain
// lines. Shortened inhibit/timeout parameters keep the run brief; all
// expected timings are expressed through them.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TO   = 3000;
  localparam int HALF = 40;  // device clock half period in clk cycles

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err, busy;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy)
  );

  // line monitor, sampled on the falling clk edge
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
  int   run = 0, last_run = 0, start_cnt = 0, bad_chg = 0;
  int   last_err_cyc = 0;
  logic prev_doe = 1'b0;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (tx_done && tx_err) both_cnt++;
    if (tx_valid && tx_ready) acc_cnt++;
    if (ps2_clk_oe) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (ps2_clk_oe && ps2_data_oe) start_cnt++;
    // data may only move while the clock line is low
    if ((ps2_data_oe != prev_doe) && ps2_clk_line) bad_chg++;
    prev_doe = ps2_data_oe;
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic host_send(input logic [7:0] d);
    @(negedge clk);
    check("ready_before_send", 32'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    tx_valid = 1'b0;
  endtask

  // keyboard model: waits for the request-to-send, then produces n_clk
  // clock pulses, sampling the data line just before each rising edge
  task automatic dev_run(input int n_clk, input bit do_ack, output logic [9:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && (w < INH + 50)) begin
      @(negedge clk);
      w++;
    end
    check("dev_saw_request", 32'(w < INH + 50), 1);
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= n_clk; k++) begin
      if ((k == 11) && do_ack) begin
        dev_data_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k <= 10) bits[k-1] = ps2_data_line;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_end(input int base, input int bound);
    int w;
    w = 0;
    while (((done_cnt + err_cnt) == base) && (w < bound)) begin
      @(negedge clk);
      w++;
    end
    check("end_within_bound", 32'(w < bound), 1);
  endtask

  task automatic xfer_ok(input logic [7:0] d, input logic par, input string name);
    int d0, e0, s0, b0;
    logic [9:0] bits;
    d0 = done_cnt; e0 = err_cnt; s0 = start_cnt; b0 = bad_chg;
    host_send(d);
    @(negedge clk);
    check({name, "_busy"}, 32'(busy), 1);
    check({name, "_ready_low"}, 32'(tx_ready), 0);
    dev_run(11, 1'b1, bits);
    wait_end(d0 + e0, 200);
    repeat (3) @(negedge clk);
    check({name, "_data_bits"}, 32'(bits[7:0]), 32'(d));
    check({name, "_parity"}, 32'(bits[8]), 32'(par));
    check({name, "_stop"}, 32'(bits[9]), 1);
    check({name, "_done_pulses"}, 32'(done_cnt - d0), 1);
    check({name, "_err_pulses"}, 32'(err_cnt - e0), 0);
    check({name, "_inhibit_len"}, 32'(last_run), INH);
    check({name, "_start_cycles"}, 32'(start_cnt - s0), 1);
    check({name, "_data_moved_clk_high"}, 32'(bad_chg - b0), 0);
    check({name, "_clk_oe_after"}, 32'(ps2_clk_oe), 0);
    check({name, "_data_oe_after"}, 32'(ps2_data_oe), 0);
    check({name, "_ready_after"}, 32'(tx_ready), 1);
  endtask

  // stimulus
  initial begin
    int d0, e0, a0;
    logic [9:0] bits;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_data_oe", 32'(ps2_data_oe), 0);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(tx_done), 0);
    check("rst_err", 32'(tx_err), 0);
    rst = 1'b1;
    @(negedge clk);

    // 0xED: bits 1,0,1,1,0,1,1,1, six ones -> parity 1
    xfer_ok(8'hED, 1'b1, "ed");
    // 0x00: no ones -> parity 1
    xfer_ok(8'h00, 1'b1, "zero");

    // device leaves data high on fall 11
    d0 = done_cnt; e0 = err_cnt;
    host_send(8'h55);
    dev_run(11, 1'b0, bits);
    wait_end(d0 + e0, 200);
    repeat (3) @(negedge clk);
    check("nack_data_bits", 32'(bits[7:0]), 32'h55);
    check("nack_err_pulses", 32'(err_cnt - e0), 1);
    check("nack_done_pulses", 32'(done_cnt - d0), 0);
    check("nack_clk_oe", 32'(ps2_clk_oe), 0);
    check("nack_data_oe", 32'(ps2_data_oe), 0);

    // device never clocks
    d0 = done_cnt; e0 = err_cnt;
    host_send(8'h12);
    wait_end(d0 + e0, TO + 100);
    repeat (2) @(negedge clk);
    check("to_latency", 32'(last_err_cyc - acc_cyc), TO);
    check("to_err_pulses", 32'(err_cnt - e0), 1);
    check("to_done_pulses", 32'(done_cnt - d0), 0);
    check("to_clk_oe", 32'(ps2_clk_oe), 0);
    check("to_data_oe", 32'(ps2_data_oe), 0);

    // reset after fall 4 of 0xA5 (bit 3 is 0, so data is being pulled low)
    d0 = done_cnt; e0 = err_cnt;
    host_send(8'hA5);
    dev_run(4, 1'b0, bits);
    check("mid_low_nibble", 32'(bits[3:0]), 32'h5);
    check("mid_data_oe_pre", 32'(ps2_data_oe), 1);
    check("mid_busy_pre", 32'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("mid_rst_data_oe", 32'(ps2_data_oe), 0);
    check("mid_rst_ready", 32'(tx_ready), 1);
    check("mid_rst_busy", 32'(busy), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - d0), 0);
    check("mid_rst_no_err", 32'(err_cnt - e0), 0);
    // 0xF4: five ones -> parity 0
    xfer_ok(8'hF4, 1'b0, "f4");

    // tx_valid held through a whole transfer; 0x3C has four ones -> parity 1
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    @(negedge clk);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    dev_run(11, 1'b1, bits);
    check("hold_first_accepts", 32'(acc_cnt - a0), 1);
    wait_end(d0 + e0, 200);
    check("hold_data_bits", 32'(bits[7:0]), 32'h3C);
    check("hold_parity", 32'(bits[8]), 1);
    check("hold_first_done", 32'(done_cnt - d0), 1);
    repeat (3) @(negedge clk);
    check("hold_second_accepts", 32'(acc_cnt - a0), 2);
    check("hold_second_busy", 32'(busy), 1);
    tx_valid = 1'b0;
    dev_run(11, 1'b1, bits);
    wait_end(d0 + e0 + 1, 200);
    repeat (3) @(negedge clk);
    check("hold_second_bits", 32'(bits[7:0]), 32'h3C);
    check("hold_total_done", 32'(done_cnt - d0), 2);
    check("hold_total_accepts", 32'(acc_cnt - a0), 2);
    check("hold_no_err", 32'(err_cnt - e0), 0);

    check("done_err_overlap", 32'(both_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 12000, clk cycles PS2_CLK is held low before start (120 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1500000, maximum cycles from leaving IDLE to reaching DONE (15 ms).
REQ-003 SHALL have port clk  input  1  system clock (100 MHz), all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset: one clock, synchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  command byte to send to the keyboard.
REQ-006 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-007 SHALL have port tx_ready  output  1  high only in IDLE; transfer accepted when tx_valid && tx_ready.
REQ-008 SHALL have port ps2_clk_in  input  1  sampled PS2_CLK line level.
REQ-009 SHALL have port ps2_data_in  input  1  sampled PS2_DATA line level.
REQ-010 SHALL have port ps2_clk_oe  output  1  1 = drive PS2_CLK low, 0 = release (open drain).
REQ-011 SHALL have port ps2_data_oe  output  1  1 = drive PS2_DATA low, 0 = release.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse, byte sent and acknowledged.
REQ-013 SHALL have port tx_err  output  1  one-cycle pulse, missing ack or timeout.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers; a falling edge (fall) is synced clk going 1 -> 0 between consecutive cycles.
REQ-016 SHALL latch tx_data and compute odd parity (parity = ~^tx_data) on the accepting cycle.
REQ-017 SHALL implement states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE, ERR.
REQ-018 IDLE: both oe = 0; on accept -> INHIBIT with cycle counter cleared.
REQ-019 INHIBIT: ps2_clk_oe = 1, ps2_data_oe = 0 for INHIBIT_CYCLES-1 cycles, then ps2_data_oe = 1 (start bit) for one cycle with ps2_clk_oe still 1, then -> REQ.
REQ-020 REQ: ps2_clk_oe = 0, ps2_data_oe = 1; fall counter cleared; -> SHIFT.
REQ-021 SHIFT: on fall k (k = 1..8) drive data bit k-1 (LSB first, ps2_data_oe = ~bit); on fall 9 drive parity; on fall 10 release data (stop bit, ps2_data_oe = 0), then -> ACK.
REQ-022 ACK: on the next fall (fall 11) sample synced data: 0 -> WAIT_IDLE, 1 -> ERR.
REQ-023 WAIT_IDLE: -> DONE when synced clk and synced data both read 1.
REQ-024 DONE: tx_done = 1 for one cycle, -> IDLE; ERR: tx_err = 1 for one cycle, both oe = 0, -> IDLE.
REQ-025 Timeout counter (>=21 bits, saturating) SHALL run from leaving IDLE; reaching TIMEOUT_CYCLES in any state other than DONE/ERR -> ERR.
REQ-026 Data output changes only on the cycle after a detected fall; no change while synced clk is high.
REQ-027 tx_valid while busy SHALL be ignored, no queuing; tx_valid on the DONE/ERR cycle is also ignored (tx_ready = 0).
REQ-028 Fall edges seen during INHIBIT SHALL be ignored and not counted.
REQ-029 tx_done and tx_err SHALL never assert in the same cycle.

Reset
REQ-030 When rst = 0 at a clock edge: state = IDLE, ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, busy = 0, tx_done = 0, tx_err = 0; all counters and synchronizers cleared to idle-line value 1.
REQ-031 Reset mid-transfer SHALL release both lines on the same edge, with no tx_done or tx_err pulse.

Verification
REQ-032 Send 0xED with the device model clocking at 12.5 kHz and acking -> ps2_clk_oe low for 12000 cycles; data bits 1,0,1,1,0,1,1,1 then parity 1, stop released; tx_done pulses once.
REQ-033 Send 0x00 -> eight 0 bits, parity 1; tx_done pulses once.
REQ-034 Device model leaves data high on fall 11 -> tx_err pulses once, no tx_done, both oe = 0 afterward.
REQ-035 Device model never clocks -> tx_err pulses 1500000 cycles after accept; lines released.
REQ-036 rst = 0 after fall 4 -> both oe = 0 on next edge, tx_ready = 1; a following 0xF4 send completes normally.
REQ-037 tx_valid held high through a full transfer -> exactly one transfer; a second one starts only after returning to IDLE.
